ram_bytewise_dp: RTL and testbench
==================================

Name: ram_bytewise_dp

Overview:
- Parametrised simple dual-port block RAM: one write port, one read port, per-byte write strobes, 1-cycle registered read.
- Adds a valid/ready handshake on both ports and a post-reset zero-fill sweep, so contents are deterministic after reset.
- Sits under the core as the instruction/data store. Supersedes the fixed 32-bit, always-ready memory.

Parameters:
- ADDR_WIDTH, 11, number of word-address bits; depth DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8, otherwise elaboration error. Derived localparam LANES = DATA_WIDTH/8.
- INIT_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = no sweep, ports ready right after reset, contents undefined.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  global stall; when 0, no state changes (memory, FSM, counters, outputs all hold).
- o_init_busy  out  1  high while the zero-fill sweep runs.
- i_write_valid  in  1  write request.
- o_write_ready  out  1  write port can accept.
- i_write_addr  in  ADDR_WIDTH  word address.
- i_write_data  in  DATA_WIDTH  write data.
- i_write_strb  in  LANES  byte-lane enables; bit k covers bits [8k+7:8k].
- i_read_valid  in  1  read request.
- o_read_ready  out  1  read port can accept.
- i_read_addr  in  ADDR_WIDTH  word address.
- o_read_data  out  DATA_WIDTH  read data; holds its last value until the next read completes.
- o_read_valid  out  1  one-cycle pulse marking new o_read_data.

Behaviour:
- FSM states: INIT, RUN.
- Reset (async assert):
  - state = INIT if INIT_ON_RESET = 1, else RUN.
  - sweep counter = 0.
  - o_read_data = 0, o_read_valid = 0.
  - o_init_busy = INIT_ON_RESET.
  - Memory contents are not reset asynchronously.
- INIT:
  - Each cycle with clk_en = 1: mem[cnt] <= 0, cnt <= cnt + 1.
  - On the cycle cnt = DEPTH-1 is written, state <= RUN.
  - o_init_busy = 1 for exactly DEPTH clk_en-qualified cycles.
  - o_write_ready = 0, o_read_ready = 0; requests are ignored, not queued.
- RUN:
  - o_write_ready = o_read_ready = 1, o_init_busy = 0.
  - Write fire = i_write_valid & o_write_ready & clk_en. Updates only the strobed lanes of mem[i_write_addr].
  - A fire with strb all zero is accepted and changes nothing.
  - Read fire = i_read_valid & o_read_ready & clk_en. On the next edge, o_read_data <= word and o_read_valid <= 1.
  - Read latency is 1 cycle.
  - o_read_valid falls on the next clk_en cycle with no read fire.
- Back-to-back reads every cycle give o_read_valid continuously high with data updating each cycle.
- Same-cycle read and write to the same address: read-first, so old word returned unless RAM_WR_BYPASS_EN.
- Reads and writes to different addresses in the same cycle are independent.
- clk_en = 0: o_read_valid and o_read_data hold; sweep pauses; a pending request is not accepted.
- rst mid-sweep: counter returns to 0 and the full sweep restarts.
- rst in RUN: returns to INIT when INIT_ON_RESET = 1, which zeroes all memory again.
- Addresses cover the full DEPTH; there is no out-of-range case.

Optional Feature:
- RAM_WR_BYPASS_EN defined: same-cycle same-address read and write returns the merged word. Strobed lanes take i_write_data; other lanes keep the old contents.
- Adds one address comparator and a LANES-wide mux on the read path.
- Undefined: read-first, so the read returns the pre-write word. No comparator is present.

Test Plan:
- Power-on and sweep (ADDR_WIDTH=4, INIT_ON_RESET=1, clk_en=1):
  - Release rst → o_init_busy high for exactly 16 cycles, both readies 0.
  - Then read addr 9 → o_read_valid 1 cycle later, data 0x00000000.
- Byte strobes: write 0xAABBCCDD strb 4'b0101 to addr 3, then read addr 3 → 0x00BB00DD.
  - Then write 0x11223344 strb 4'b1010 → read 0x11BB33DD.
- Same-address collision: mem[5]=0x11223344; same cycle write 0xFFFFFFFF strb 4'b0011 and read addr 5.
  - Without macro → 0x11223344.
  - With RAM_WR_BYPASS_EN → 0x1122FFFF.
  - Either way, a following read → 0x1122FFFF.
- Stall: issue read of addr 3 with clk_en low for 3 cycles → no o_read_valid, outputs frozen.
  - Raise clk_en → o_read_valid exactly 1 cycle later.
- Reset mid-sweep: assert rst when cnt = 7 → o_init_busy stays high.
  - After release, 16 full sweep cycles again; read addr 3 → 0x00000000.
- Requests during INIT: hold i_write_valid with addr 2, data 0xDEADBEEF → no write occurs.
  - After sweep, read addr 2 → 0x00000000, since the request was not queued.

Source files
------------

// File: rtl/ram_bytewise_dp.sv
// Simple dual-port RAM with byte strobes, valid/ready ports and a post-reset zero-fill sweep.
// Define RAM_WR_BYPASS_EN to forward same-cycle same-address write lanes onto the read data.
module ram_bytewise_dp #(
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  output logic                      o_init_busy,
  input  logic                      i_write_valid,
  output logic                      o_write_ready,
  input  logic [ADDR_WIDTH-1:0]     i_write_addr,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  input  logic [DATA_WIDTH/8-1:0]   i_write_strb,
  input  logic                      i_read_valid,
  output logic                      o_read_ready,
  input  logic [ADDR_WIDTH-1:0]     i_read_addr,
  output logic [DATA_WIDTH-1:0]     o_read_data,
  output logic                      o_read_valid
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned LANES = DATA_WIDTH/8;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("ram_bytewise_dp: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_read_data;
  logic                    r_read_valid;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic                    w_init_busy;
  logic                    w_write_ready;
  logic                    w_read_ready;
  logic                    w_write_fire;
  logic                    w_read_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= INIT_ON_RESET ? S_INIT : S_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == S_INIT && clk_en && r_cnt == '1) w_state_next = S_RUN;
  end

  always_comb begin
    w_init_busy   = (r_state == S_INIT);
    w_write_ready = (r_state == S_RUN);
    w_read_ready  = (r_state == S_RUN);
  end

  assign w_write_fire = i_write_valid & w_write_ready & clk_en;
  assign w_read_fire  = i_read_valid  & w_read_ready  & clk_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_cnt <= '0;
    else if (clk_en && r_state == S_INIT)   r_cnt <= r_cnt + 1'b1;
  end

  // Memory array carries no reset; the sweep provides deterministic contents instead.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (r_state == S_INIT) begin
        r_mem[r_cnt] <= '0;
      end else if (w_write_fire) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          if (i_write_strb[k]) r_mem[i_write_addr][8*k +: 8] <= i_write_data[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rd_word = r_mem[i_read_addr];
`ifdef RAM_WR_BYPASS_EN
    if (w_write_fire && i_write_addr == i_read_addr) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (i_write_strb[k]) w_rd_word[8*k +: 8] = i_write_data[8*k +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else if (clk_en) begin
      if (w_read_fire) begin
        r_read_data  <= w_rd_word;
        r_read_valid <= 1'b1;
      end else begin
        r_read_valid <= 1'b0;
      end
    end
  end

  assign o_init_busy   = w_init_busy;
  assign o_write_ready = w_write_ready;
  assign o_read_ready  = w_read_ready;
  assign o_read_data   = r_read_data;
  assign o_read_valid  = r_read_valid;

endmodule

// File: tb/tb_ram_bytewise_dp.sv
// Scoreboard bench for ram_bytewise_dp: reference word array, expected-read queue, negedge monitor.
module tb_ram_bytewise_dp;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          o_init_busy;
  logic          i_write_valid;
  logic          o_write_ready;
  logic [AW-1:0] i_write_addr;
  logic [DW-1:0] i_write_data;
  logic [LN-1:0] i_write_strb;
  logic          i_read_valid;
  logic          o_read_ready;
  logic [AW-1:0] i_read_addr;
  logic [DW-1:0] o_read_data;
  logic          o_read_valid;

  ram_bytewise_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .o_init_busy(o_init_busy),
    .i_write_valid(i_write_valid), .o_write_ready(o_write_ready),
    .i_write_addr(i_write_addr), .i_write_data(i_write_data), .i_write_strb(i_write_strb),
    .i_read_valid(i_read_valid), .o_read_ready(o_read_ready), .i_read_addr(i_read_addr),
    .o_read_data(o_read_data), .o_read_valid(o_read_valid)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          en_at_edge = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [LN-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < LN; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // New read data is present only when the preceding edge was enabled.
  always @(posedge clk) en_at_edge = clk_en;

  always @(negedge clk) begin
    if (o_read_valid && en_at_edge) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got valid data 0x%08h expected no read", o_read_data);
      end else begin
        check("read_data", o_read_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] s);
    i_write_valid = 1'b1; i_write_addr = a; i_write_data = d; i_write_strb = s;
    @(posedge clk); #1;
    i_write_valid = 1'b0;
    model[a] = merge(model[a], d, s);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    i_read_valid = 1'b1; i_read_addr = a;
    exp_q.push_back(model[a]);
    @(posedge clk); #1;
    i_read_valid = 1'b0;
  endtask

  task automatic wait_sweep(output int len, output logic saw_ready);
    len = 0;
    saw_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!o_init_busy) break;
      len++;
      if (o_write_ready || o_read_ready) saw_ready = 1'b1;
    end
  endtask

  task automatic sweep_and_check(input string tag);
    int   len;
    logic sr;
    wait_sweep(len, sr);
    check({tag, "_sweep_len"}, 32'(len), 32'(DEPTH));
    check({tag, "_ready_in_init"}, 32'(sr), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  logic [DW-1:0] held;
  logic          r_en, r_wv, r_rv;
  logic [AW-1:0] r_wa, r_ra;
  logic [DW-1:0] r_wd;
  logic [LN-1:0] r_ws;

  initial begin
    rst = 1'b1; clk_en = 1'b1;
    i_write_valid = 1'b0; i_write_addr = '0; i_write_data = '0; i_write_strb = '0;
    i_read_valid = 1'b0; i_read_addr = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_busy", 32'(o_init_busy), 32'd1);
    check("rst_write_ready", 32'(o_write_ready), 32'd0);
    check("rst_read_ready", 32'(o_read_ready), 32'd0);
    check("rst_read_valid", 32'(o_read_valid), 32'd0);
    check("rst_read_data", o_read_data, 32'd0);
    rst = 1'b0;
    sweep_and_check("poweron");

    do_read(4'd9);
    @(negedge clk);
    check("read_latency", 32'(o_read_valid), 32'd1);
    idle(2);

    do_write(4'd3, 32'hAABBCCDD, 4'b0101);
    do_read(4'd3);
    do_write(4'd3, 32'h11223344, 4'b1010);
    do_read(4'd3);
    idle(2);

    do_write(4'd5, 32'h11223344, 4'b1111);
    i_write_valid = 1'b1; i_write_addr = 4'd5; i_write_data = 32'hFFFFFFFF; i_write_strb = 4'b0011;
    i_read_valid = 1'b1; i_read_addr = 4'd5;
`ifdef RAM_WR_BYPASS_EN
    exp_q.push_back(merge(model[5], 32'hFFFFFFFF, 4'b0011));
`else
    exp_q.push_back(model[5]);
`endif
    @(posedge clk); #1;
    i_write_valid = 1'b0; i_read_valid = 1'b0;
    model[5] = merge(model[5], 32'hFFFFFFFF, 4'b0011);
    do_read(4'd5);
    idle(2);

    held = model[5];
    clk_en = 1'b0;
    i_read_valid = 1'b1; i_read_addr = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(o_read_valid), 32'd0);
      check("stall_data", o_read_data, held);
    end
    exp_q.push_back(model[3]);
    clk_en = 1'b1;
    @(posedge clk); #1;
    i_read_valid = 1'b0;
    @(negedge clk);
    check("stall_release_latency", 32'(o_read_valid), 32'd1);
    idle(2);

    for (int c = 0; c < 300; c++) begin
      r_en = ($urandom_range(0, 9) != 0);
      r_wv = 1'($urandom_range(0, 1));
      r_rv = 1'($urandom_range(0, 1));
      r_wa = 4'($urandom_range(0, 15));
      r_ra = ($urandom_range(0, 3) == 0) ? r_wa : 4'($urandom_range(0, 15));
      r_wd = $urandom;
      r_ws = 4'($urandom_range(0, 15));
      clk_en = r_en;
      i_write_valid = r_wv; i_write_addr = r_wa; i_write_data = r_wd; i_write_strb = r_ws;
      i_read_valid = r_rv; i_read_addr = r_ra;
      if (r_en && r_rv) begin
`ifdef RAM_WR_BYPASS_EN
        if (r_wv && r_wa == r_ra) exp_q.push_back(merge(model[r_ra], r_wd, r_ws));
        else                      exp_q.push_back(model[r_ra]);
`else
        exp_q.push_back(model[r_ra]);
`endif
      end
      if (r_en && r_wv) model[r_wa] = merge(model[r_wa], r_wd, r_ws);
      @(posedge clk); #1;
    end
    clk_en = 1'b1; i_write_valid = 1'b0; i_read_valid = 1'b0;
    idle(3);

    do_write(4'd3, 32'hCAFEF00D, 4'b1111);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midsweep_busy", 32'(o_init_busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_and_check("midsweep");
    do_read(4'd3);
    idle(2);

    rst = 1'b1;
    i_write_valid = 1'b1; i_write_addr = 4'd2; i_write_data = 32'hDEADBEEF; i_write_strb = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_and_check("initreq");
    i_write_valid = 1'b0;
    do_read(4'd2);
    idle(3);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
